// File: rtl/jk_op_sequencer.sv
// JK op sequencer: buffers hold/reset/set/toggle ops, drives j/k into a JK flop one op at a time
// and checks the returned q against a shadow model. Optional build macro: JKSEQ_ERR_STOP_EN.
module jk_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  output logic             j,
  output logic             k,
  input  logic             q_in,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef JKSEQ_ERR_STOP_EN
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       mem_q [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             j_q, j_d, k_q, k_d;
  logic             known_q, known_d, exp_q, exp_d;
  logic [CNT_W-1:0] done_q, done_d, errc_q, errc_d;
  logic [1:0]       head;
  logic             empty, full, halted, push, pop, mismatch;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
`ifdef JKSEQ_ERR_STOP_EN
  assign halted = (state_q == S_HALT);
`else
  assign halted = 1'b0;
`endif
  assign op_ready = !full && !halted;
  assign push     = op_valid && op_ready;
  // q_in already reflects the op sampled at the end of DRIVE; unknown flop state is never checked.
  assign mismatch = (state_q == S_CHECK) && known_q && (q_in != exp_q);

  assign j          = j_q;
  assign k          = k_q;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign done_count = done_q;
  assign err_count  = errc_q;
  assign err        = mismatch;

  always_comb begin
    state_d = state_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    known_d = known_q;
    exp_d   = exp_q;
    done_d  = done_q;
    errc_d  = errc_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end
      S_DRIVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        done_d = sat_inc(done_q);
        if (mismatch) errc_d = sat_inc(errc_q);
        if (!empty) pop = 1'b1;
        else        state_d = S_IDLE;
`ifdef JKSEQ_ERR_STOP_EN
        if (mismatch) begin
          pop     = 1'b0;
          state_d = S_HALT;
        end
`endif
      end
      default: ;
    endcase

    // Entering DRIVE: pop the head, present it on j/k and advance the shadow flop.
    if (pop) begin
      state_d = S_DRIVE;
      j_d     = head[1];
      k_d     = head[0];
      case (head)
        2'b01: begin exp_d = 1'b0; known_d = 1'b1; end
        2'b10: begin exp_d = 1'b1; known_d = 1'b1; end
        2'b11: exp_d = ~exp_q;
        default: ;
      endcase
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      known_q  <= 1'b0;
      exp_q    <= 1'b0;
      done_q   <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      known_q  <= known_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      errc_q   <= errc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= op_code;
  end
endmodule

// File: tb/tb_jk_op_sequencer.sv
// Bench for jk_op_sequencer: directed steps plus random op streams, checked against a
// transaction-level model of the op queue and the JK shadow value.
module tb_jk_op_sequencer;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, op_valid;
  logic [1:0] op_code;
  logic       op_ready, j, k, busy, err;
  logic [7:0] done_count, err_count;
  logic       q_ff, q_in, fault, force_x, force_zero, rand_fault_en;
  logic       op_ready_s, j_s, k_s, busy_s, err_s, q_ff_s;
  logic [1:0] done_s, errc_s;

  assign q_in = force_x ? 1'bx : (force_zero ? 1'b0 : (q_ff ^ fault));

  jk_op_sequencer #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .j(j), .k(k), .q_in(q_in), .busy(busy), .done_count(done_count),
    .err_count(err_count), .err(err));

  jk_op_sequencer #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready_s),
    .j(j_s), .k(k_s), .q_in(q_ff_s), .busy(busy_s), .done_count(done_s),
    .err_count(errc_s), .err(err_s));

  // Behavioural JK flops fed by each sequencer.
  always_ff @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    case ({j_s, k_s})
      2'b01:   q_ff_s <= 1'b0;
      2'b10:   q_ff_s <= 1'b1;
      2'b11:   q_ff_s <= ~q_ff_s;
      default: ;
    endcase
  end

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_ops[$];
  logic       m_known, m_exp;
  int         exp_err_total, err_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    fault = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fault = rand_fault_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Completion monitor: a done_count step means the op driven two cycles earlier was checked
  // in the previous cycle.
  initial begin
    logic [1:0] jk_h1, jk_h2, op;
    logic       err_h1, q_h1, e_err;
    logic [7:0] done_prev;
    jk_h1 = '0; jk_h2 = '0; err_h1 = 1'b0; q_h1 = 1'b0; done_prev = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        jk_h1 = '0; jk_h2 = '0; err_h1 = 1'b0; q_h1 = 1'b0; done_prev = '0;
      end else begin
        if (err === 1'b1) err_cycles++;
        if (done_count !== done_prev) begin
          chk("done_step", 32'(done_count), 32'(done_prev) + 32'd1);
          checks++;
          assert (exp_ops.size() != 0) else begin
            errors++;
            $error("FAIL op_order: observed a completion, expected no op outstanding");
          end
          if (exp_ops.size() != 0) begin
            op = exp_ops.pop_front();
            chk("jk_drive", 32'(jk_h2), 32'(op));
            case (op)
              2'b01:   begin m_exp = 1'b0; m_known = 1'b1; end
              2'b10:   begin m_exp = 1'b1; m_known = 1'b1; end
              2'b11:   m_exp = ~m_exp;
              default: ;
            endcase
            e_err = m_known && (q_h1 !== m_exp);
            if (e_err) exp_err_total++;
            chk("err_pulse", 32'(err_h1), 32'(e_err));
          end
        end
        jk_h2 = jk_h1; jk_h1 = {j, k}; err_h1 = err; q_h1 = q_in; done_prev = done_count;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic drop();
    @(negedge clk);
    op_valid = 1'b0;
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; op_valid = 1'b0;
    exp_ops.delete();
    m_known = 1'b0; m_exp = 1'b0; exp_err_total = 0; err_cycles = 0;
    step();
    rst = 1'b0;
  endtask

  // Holds op_valid until accepted; stalls counts cycles refused by op_ready.
  task automatic push(input logic [1:0] op, inout int stalls);
    bit rdy;
    rdy = 1'b0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    for (int n = 0; n < 50 && !rdy; n++) begin
      #1;
      rdy = op_ready;
      @(posedge clk);
      if (rdy) exp_ops.push_back(op);
      else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL push_timeout: observed op_ready low 50 cycles, required acceptance");
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    drop();
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int   st;
    logic prev_busy;
    rst = 1'b1; op_valid = 1'b0; op_code = 2'b00;
    force_x = 1'b0; force_zero = 1'b0; rand_fault_en = 1'b0;
    m_known = 1'b0; m_exp = 1'b0; exp_err_total = 0; err_cycles = 0; st = 0;
    repeat (2) step();
    chk("rst_jk", 32'({j, k}), 32'd0);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);
    chk("rst_errc", 32'(err_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // set, toggle, toggle, reset with a healthy flop
    push(2'b10, st);
    drop();
    chk("lat_idle_jk", 32'({j, k}), 32'd0);
    step();
    chk("lat_drive_jk", 32'({j, k}), 32'b10);
    step();
    chk("lat_check_jk", 32'({j, k}), 32'd0);
    push(2'b11, st); push(2'b11, st); push(2'b01, st);
    drop();
    prev_busy = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (done_count == 8'd4) break;
      prev_busy = busy;
      step();
    end
    chk("t1_done", 32'(done_count), 32'd4);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_busy_before", 32'(prev_busy), 32'd1);
    chk("t1_errc", 32'(err_count), 32'd0);
    chk("t1_sat_done", 32'(done_s), 32'd3);

    // hold, toggle from unknown flop state: counted, never checked
    do_reset();
    force_x = 1'b1;
    push(2'b00, st); push(2'b11, st);
    wait_idle("t2_idle");
    chk("t2_done", 32'(done_count), 32'd2);
    chk("t2_err_cycles", 32'(err_cycles), 32'd0);
    chk("t2_errc", 32'(err_count), 32'd0);
    force_x = 1'b0;

    // back-to-back burst deep enough to fill the FIFO
    do_reset();
    st = 0;
    for (int i = 0; i < 8; i++) push(2'($urandom_range(0, 3)), st);
    wait_idle("t3_idle");
    chk("t3_backpressure", 32'(st > 0), 32'd1);
    chk("t3_done", 32'(done_count), 32'd8);
    chk("t3_errc", 32'(err_count), 32'd0);

    // set with q stuck at 0, then a toggle queued behind it
    do_reset();
    force_zero = 1'b1;
    push(2'b10, st); push(2'b11, st);
`ifdef JKSEQ_ERR_STOP_EN
    drop();
    repeat (12) step();
    chk("t4_done", 32'(done_count), 32'd1);
    chk("t4_errc", 32'(err_count), 32'd1);
    chk("t4_err_cycles", 32'(err_cycles), 32'd1);
    chk("t4_halt_ready", 32'(op_ready), 32'd0);
    chk("t4_halt_busy", 32'(busy), 32'd1);
    chk("t4_halt_jk", 32'({j, k}), 32'd0);
`else
    wait_idle("t4_idle");
    chk("t4_done", 32'(done_count), 32'd2);
    chk("t4_errc", 32'(err_count), 32'd1);
    chk("t4_err_cycles", 32'(err_cycles), 32'd1);
`endif
    force_zero = 1'b0;

    // reset during the DRIVE of the 2nd of 3 queued ops
    do_reset();
    push(2'b10, st); push(2'b01, st); push(2'b11, st);
    drop();
    for (int n = 0; n < 50; n++) begin
      if (done_count == 8'd1) break;
      step();
    end
    chk("t5_drive2_jk", 32'({j, k}), 32'b01);
    rst = 1'b1;
    exp_ops.delete();
    m_known = 1'b0; m_exp = 1'b0; exp_err_total = 0; err_cycles = 0;
    step();
    chk("t5_jk", 32'({j, k}), 32'd0);
    chk("t5_ready", 32'(op_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done_count), 32'd0);
    chk("t5_errc", 32'(err_count), 32'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("t5_stay_idle", 32'({busy, j, k}), 32'd0);

    // CNT_W=2 instance saturates
    do_reset();
    for (int i = 0; i < 5; i++) push(2'b10, st);
    wait_idle("t6_idle");
    chk("t6_sat_done", 32'(done_s), 32'd3);
    chk("t6_done", 32'(done_count), 32'd5);
    chk("t6_sat_errc", 32'(errc_s), 32'd0);

    // random ops with random gaps; random q corruption when sequencing continues on mismatch
    do_reset();
`ifndef JKSEQ_ERR_STOP_EN
    rand_fault_en = 1'b1;
`endif
    for (int i = 0; i < 30; i++) begin
      int g;
      push(2'($urandom_range(0, 3)), st);
      g = int'($urandom_range(0, 2));
      if (g > 0) begin
        drop();
        repeat (g - 1) step();
      end
    end
    wait_idle("t7_idle");
    rand_fault_en = 1'b0;
    chk("t7_done", 32'(done_count), 32'd30);
    chk("t7_errc", 32'(err_count), 32'(exp_err_total));
    chk("t7_err_cycles", 32'(err_cycles), 32'(exp_err_total));
    chk("t7_drained", 32'(exp_ops.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion, required finish before 400000");
    $fatal(1, "watchdog");
  end
endmodule
